// File: rtl/wb_ram_arbiter_pkg.sv
// Package for the CFU RAM arbiter slice.
// Provides the arbiter FSM state type and the fixed Wishbone cycle-type and
// burst-type codes driven on cfu_ram_cti / cfu_ram_bte.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS,
    ARB_RESP
  } arb_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_ram_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans the request vector starting one position after the last grant
// (wrapping modulo N) and returns the first requester found.
// Ports:
//   req      N-bit request vector
//   last     index of the most recent grant
//   gnt_idx  index of the chosen requester (0 when none)
//   gnt_any  1 when at least one request is set
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int unsigned IW = $clog2(N);

  int unsigned       cand;
  logic [IW-1:0]     cand_idx;

  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand     = (32'(last) + off) % N;
      cand_idx = IW'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Shares the single CFU Wishbone RAM master port among NUM_REQ requesters.
// Round-robin grant, one classic single-beat transaction at a time, with a
// bus timeout that forces an error completion.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/we/adr/wdata/sel        per-requester request (packed, i-th slice)
//   rsp_valid                         one-cycle completion pulse per requester
//   rsp_err, rsp_rdata                shared response qualifiers, held until next RESP
//   busy                              arbiter not idle
//   cfu_ram_*                         Wishbone master port (registered outputs)
module wb_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*30-1:0] req_adr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_sel,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  busy,
  output logic [29:0]           cfu_ram_adr,
  output logic [31:0]           cfu_ram_dat_mosi,
  output logic [3:0]            cfu_ram_sel,
  output logic                  cfu_ram_cyc,
  output logic                  cfu_ram_stb,
  output logic                  cfu_ram_we,
  output logic [2:0]            cfu_ram_cti,
  output logic [1:0]            cfu_ram_bte,
  input  logic [31:0]           cfu_ram_dat_miso,
  input  logic                  cfu_ram_ack,
  input  logic                  cfu_ram_err
);

  localparam int unsigned       IW       = $clog2(NUM_REQ);
  localparam int unsigned       CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t     state;
  logic [IW-1:0]  grant;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  win_idx;
  logic           win_any;
  logic [CW-1:0]  cnt;

  logic           win_we;
  logic [29:0]    win_adr;
  logic [31:0]    win_wdata;
  logic [3:0]     win_sel;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req_valid),
    .last    (last_grant),
    .gnt_idx (win_idx),
    .gnt_any (win_any)
  );

  always_comb begin
    win_we    = 1'b0;
    win_adr   = '0;
    win_wdata = '0;
    win_sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_we    = req_we[i];
        win_adr   = req_adr[30*i +: 30];
        win_wdata = req_wdata[32*i +: 32];
        win_sel   = req_sel[4*i +: 4];
      end
    end
  end

  assign busy        = (state != ARB_IDLE);
  assign cfu_ram_cti = WB_CTI_CLASSIC;
  assign cfu_ram_bte = WB_BTE_LINEAR;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ARB_IDLE;
      grant            <= '0;
      last_grant       <= IW'(NUM_REQ - 1);
      cnt              <= '0;
      cfu_ram_cyc      <= 1'b0;
      cfu_ram_stb      <= 1'b0;
      cfu_ram_we       <= 1'b0;
      cfu_ram_adr      <= '0;
      cfu_ram_dat_mosi <= '0;
      cfu_ram_sel      <= '0;
      rsp_valid        <= '0;
      rsp_err          <= 1'b0;
      rsp_rdata        <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ARB_IDLE: begin
          if (win_any) begin
            grant            <= win_idx;
            cfu_ram_we       <= win_we;
            cfu_ram_adr      <= win_adr;
            cfu_ram_dat_mosi <= win_wdata;
            cfu_ram_sel      <= win_sel;
            cnt              <= '0;
            cfu_ram_cyc      <= 1'b1;
            cfu_ram_stb      <= 1'b1;
            state            <= ARB_BUS;
          end
        end
        ARB_BUS: begin
          // err beats ack; ack beats the timeout, even in the final cycle
          if (cfu_ram_err || cfu_ram_ack || (cnt == CNT_LAST)) begin
            cfu_ram_cyc <= 1'b0;
            cfu_ram_stb <= 1'b0;
            rsp_valid   <= NUM_REQ'(1) << grant;
            state       <= ARB_RESP;
            if (!cfu_ram_err && cfu_ram_ack) begin
              rsp_err   <= 1'b0;
              rsp_rdata <= cfu_ram_we ? '0 : cfu_ram_dat_miso;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB_RESP: begin
          last_grant <= grant;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_we;
  logic [NR*30-1:0] req_adr;
  logic [NR*32-1:0] req_wdata;
  logic [NR*4-1:0] req_sel;
  logic [NR-1:0]   rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;
  logic            busy;
  logic [29:0]     cfu_ram_adr;
  logic [31:0]     cfu_ram_dat_mosi;
  logic [3:0]      cfu_ram_sel;
  logic            cfu_ram_cyc;
  logic            cfu_ram_stb;
  logic            cfu_ram_we;
  logic [2:0]      cfu_ram_cti;
  logic [1:0]      cfu_ram_bte;
  logic [31:0]     cfu_ram_dat_miso;
  logic            cfu_ram_ack;
  logic            cfu_ram_err;

  always #5 clk = ~clk;

  wb_ram_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_adr          (req_adr),
    .req_wdata        (req_wdata),
    .req_sel          (req_sel),
    .rsp_valid        (rsp_valid),
    .rsp_err          (rsp_err),
    .rsp_rdata        (rsp_rdata),
    .busy             (busy),
    .cfu_ram_adr      (cfu_ram_adr),
    .cfu_ram_dat_mosi (cfu_ram_dat_mosi),
    .cfu_ram_sel      (cfu_ram_sel),
    .cfu_ram_cyc      (cfu_ram_cyc),
    .cfu_ram_stb      (cfu_ram_stb),
    .cfu_ram_we       (cfu_ram_we),
    .cfu_ram_cti      (cfu_ram_cti),
    .cfu_ram_bte      (cfu_ram_bte),
    .cfu_ram_dat_miso (cfu_ram_dat_miso),
    .cfu_ram_ack      (cfu_ram_ack),
    .cfu_ram_err      (cfu_ram_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode: 0 = ack, 1 = err, 2 = ack+err together, 3 = no response
  typedef struct {
    int unsigned idx;
    logic        we;
    logic [29:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int unsigned ack_at;
    int unsigned mode;
    logic [31:0] miso;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int unsigned exp_stb;
    int unsigned exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_adr   = '0;
    req_wdata = '0;
    req_sel   = '0;
  endtask

  task automatic set_req(input int unsigned idx, input logic we, input logic [29:0] adr,
                         input logic [31:0] wdata, input logic [3:0] sel);
    req_valid[idx]          = 1'b1;
    req_we[idx]             = we;
    req_adr[30*idx +: 30]   = adr;
    req_wdata[32*idx +: 32] = wdata;
    req_sel[4*idx +: 4]     = sel;
  endtask

  task automatic run_vec(input int unsigned k, input vec_t v);
    int unsigned n     = 0;
    int unsigned stb_n = 0;
    bit          done  = 0;
    string       tag;
    tag = $sformatf("v%0d", k);
    @(negedge clk);
    set_req(v.idx, v.we, v.adr, v.wdata, v.sel);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      cfu_ram_ack = 1'b0;
      cfu_ram_err = 1'b0;
      if (cfu_ram_stb) begin
        stb_n++;
        if (stb_n == 1) begin
          chk({tag, "_cyc"}, cfu_ram_cyc, 1'b1);
          chk({tag, "_adr"}, cfu_ram_adr, v.adr);
          chk({tag, "_we"},  cfu_ram_we, v.we);
          chk({tag, "_dat"}, cfu_ram_dat_mosi, v.wdata);
          chk({tag, "_sel"}, cfu_ram_sel, v.sel);
          chk({tag, "_cti"}, cfu_ram_cti, 3'b000);
          chk({tag, "_bte"}, cfu_ram_bte, 2'b00);
          chk({tag, "_busy"}, busy, 1'b1);
        end
        if (stb_n - 1 == v.ack_at) begin
          cfu_ram_dat_miso = v.miso;
          cfu_ram_ack = (v.mode == 0 || v.mode == 2);
          cfu_ram_err = (v.mode == 1 || v.mode == 2);
        end
      end
      if (rsp_valid != '0) begin
        chk({tag, "_rsp_valid"}, rsp_valid, NR'(1) << v.idx);
        chk({tag, "_rsp_err"}, rsp_err, v.exp_err);
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_stb_cycles"}, stb_n, v.exp_stb);
        chk({tag, "_latency"}, n, v.exp_lat);
        chk({tag, "_cyc_resp"}, cfu_ram_cyc, 1'b0);
        req_valid[v.idx] = 1'b0;
        done = 1;
      end
    end
    if (!done) chk({tag, "_rsp_wait"}, 1'b0, 1'b1);
    @(negedge clk);
    chk({tag, "_pulse_one"}, rsp_valid, '0);
  endtask

  initial begin
    int unsigned got;
    int unsigned n;
    logic [29:0] rr_adr[2];

    vecs[0] = '{0, 1'b0, 30'h100, 32'h0, 4'hF, 1, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2, 3};
    vecs[1] = '{1, 1'b1, 30'h020, 32'h12345678, 4'b0011, 0, 0, 32'hAAAA5555, 1'b0, 32'h0, 1, 2};
    vecs[2] = '{0, 1'b0, 30'h0ABC, 32'h0, 4'hF, 0, 3, 32'h11111111, 1'b1, 32'h0, 8, 9};
    vecs[3] = '{1, 1'b0, 30'h1234, 32'h0, 4'hC, 2, 0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 3, 4};
    vecs[4] = '{0, 1'b0, 30'h0044, 32'h0, 4'hF, 0, 2, 32'h77777777, 1'b1, 32'h0, 1, 2};
    vecs[5] = '{1, 1'b0, 30'h0088, 32'h0, 4'h1, 7, 0, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 8, 9};
    vecs[6] = '{0, 1'b0, 30'h0099, 32'h0, 4'hF, 3, 1, 32'h55555555, 1'b1, 32'h0, 4, 5};

    reset_n          = 1'b0;
    clear_reqs();
    cfu_ram_ack      = 1'b0;
    cfu_ram_err      = 1'b0;
    cfu_ram_dat_miso = '0;

    #12;
    chk("rst_cyc", cfu_ram_cyc, 1'b0);
    chk("rst_stb", cfu_ram_stb, 1'b0);
    chk("rst_we", cfu_ram_we, 1'b0);
    chk("rst_adr", cfu_ram_adr, '0);
    chk("rst_dat", cfu_ram_dat_mosi, '0);
    chk("rst_sel", cfu_ram_sel, '0);
    chk("rst_cti", cfu_ram_cti, 3'b000);
    chk("rst_bte", cfu_ram_bte, 2'b00);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_busy", busy, 1'b0);

    // both requesters valid from reset: grants alternate 0,1,0,1
    @(negedge clk);
    reset_n   = 1'b1;
    rr_adr[0] = 30'h111;
    rr_adr[1] = 30'h222;
    set_req(0, 1'b0, rr_adr[0], 32'h0, 4'hF);
    set_req(1, 1'b0, rr_adr[1], 32'h0, 4'hF);
    got = 0;
    n   = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk);
      n++;
      cfu_ram_ack = 1'b0;
      if (cfu_ram_stb) begin
        chk($sformatf("rr%0d_adr", got), cfu_ram_adr, rr_adr[got % 2]);
        cfu_ram_dat_miso = 32'h5000_0000 + got;
        cfu_ram_ack      = 1'b1;
      end
      if (rsp_valid != '0) begin
        chk($sformatf("rr%0d_onehot", got), rsp_valid, NR'(1) << (got % 2));
        chk($sformatf("rr%0d_rdata", got), rsp_rdata, 32'h5000_0000 + got);
        chk($sformatf("rr%0d_no_overlap", got), cfu_ram_stb, 1'b0);
        got++;
        if (got == 4) clear_reqs();
      end
    end
    chk("rr_count", got, 4);
    @(negedge clk);
    cfu_ram_ack = 1'b0;

    for (int unsigned k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // reset during BUS (last completed grant was requester 0)
    @(negedge clk);
    set_req(1, 1'b0, 30'h333, 32'h0, 4'hF);
    n = 0;
    while (!cfu_ram_stb && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pre_stb", cfu_ram_stb, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cyc", cfu_ram_cyc, 1'b0);
    chk("mid_rst_stb", cfu_ram_stb, 1'b0);
    chk("mid_rst_rsp", rsp_valid, '0);
    chk("mid_rst_busy", busy, 1'b0);
    clear_reqs();
    cfu_ram_ack = 1'b1;
    @(negedge clk);
    chk("mid_hold_rsp", rsp_valid, '0);
    reset_n = 1'b1;
    for (int unsigned c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("late_ack%0d_rsp", c), rsp_valid, '0);
      chk($sformatf("late_ack%0d_busy", c), busy, 1'b0);
      chk($sformatf("late_ack%0d_stb", c), cfu_ram_stb, 1'b0);
    end
    cfu_ram_ack = 1'b0;
    set_req(0, 1'b0, 30'h044, 32'h0, 4'hF);
    set_req(1, 1'b0, 30'h055, 32'h0, 4'hF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfu_ram_stb && n < 5);
    chk("post_rst_stb", cfu_ram_stb, 1'b1);
    chk("post_rst_first_adr", cfu_ram_adr, 30'h044);
    cfu_ram_dat_miso = 32'h0000_0ACE;
    cfu_ram_ack      = 1'b1;
    @(negedge clk);
    cfu_ram_ack = 1'b0;
    chk("post_rst_rsp", rsp_valid, 2'b01);
    chk("post_rst_rdata", rsp_rdata, 32'h0000_0ACE);
    clear_reqs();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
